// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Initiator side of the data-memory port. Accepts single or burst load/fill
//   requests from the MEM stage over a valid/ready handshake, sequences the
//   memory address/rd/wr/write_data lines one beat per cycle, captures the
//   memory's combinational read data and returns each read word as a
//   one-cycle response pulse.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_req_valid/o_req_ready request handshake (ready only while idle)
//   i_req_we                1 = write/fill burst, 0 = read burst
//   i_req_addr              start word address
//   i_req_len               beats minus one
//   i_req_wdata             word written on every beat of a write burst
//   o_rsp_valid             one-cycle pulse, o_rsp_rdata holds a read word
//   o_rsp_rdata             captured read word
//   o_rsp_last              final beat of the burst (qualifies o_rsp_valid)
//   o_done                  one-cycle pulse when a burst completes
//   o_mem_addr/o_mem_wdata  memory address / write data
//   o_mem_wr/o_mem_rd       memory write / read strobes
//   i_mem_rdata             memory read data (undriven when rd=0)
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [LEN_WIDTH-1:0]  i_req_len,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_last,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_wr,
    output logic                  o_mem_rd,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_last;
    logic                  r_done;

    logic                  w_last;

    assign w_last = (r_cnt == '0);

    assign o_req_ready = (r_state == StIdle);
    // Strobes are gated by reset so no write can land on a reset edge.
    assign o_mem_rd    = (r_state == StRead) && i_rst_n;
    assign o_mem_wr    = (r_state == StWrite) && i_rst_n;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_last  = r_rsp_last;
    assign o_done      = r_done;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Response and completion flags are single-cycle pulses.
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_done      <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
                        r_cnt   <= i_req_len;
                        r_state <= i_req_we ? StWrite : StRead;
                    end
                end
                StRead: begin
                    // Only sampled here, where rd is asserted and data is driven.
                    r_rsp_rdata <= i_mem_rdata;
                    r_rsp_valid <= 1'b1;
                    r_rsp_last  <= w_last;
                    r_done      <= w_last;
                    r_addr      <= r_addr + ADDR_WIDTH'(1);
                    r_cnt       <= r_cnt - LEN_WIDTH'(1);
                    if (w_last) begin
                        r_state <= StIdle;
                    end
                end
                StWrite: begin
                    r_done <= w_last;
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                    r_cnt  <= r_cnt - LEN_WIDTH'(1);
                    if (w_last) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Purpose:
//   Self-checking bench for mem_access_unit with a behavioural 256x16 data
//   memory. Stimulus pushes expected responses (data, last flag, cycle) and
//   expected done cycles into queues; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_last;
    logic        done;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wr;
    logic        mem_rd;
    wire  [15:0] mem_rdata;

    mem_access_unit #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8),
        .LEN_WIDTH (4)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_we   (req_we),
        .i_req_addr (req_addr),
        .i_req_len  (req_len),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata),
        .o_rsp_last (rsp_last),
        .o_done     (done),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_wr   (mem_wr),
        .o_mem_rd   (mem_rd),
        .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural data memory; bench-side preset port and clear share the write block.
    logic [15:0] mem [0:255];
    logic        tb_clr = 1'b0;
    logic        tb_we = 1'b0;
    logic [7:0]  tb_addr = 8'h00;
    logic [15:0] tb_data = 16'h0000;

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
    end

    assign mem_rdata = mem_rd ? mem[mem_addr] : 16'hzzzz;

    int n_vec  = 0;
    int n_fail = 0;
    int both_hi = 0;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } rsp_t;

    rsp_t rsp_q[$];
    int   done_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every response/done pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd && mem_wr) both_hi++;
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_data", 32'(rsp_rdata), 32'(e.data));
                    chk("rsp_last", 32'(rsp_last), 32'(e.last));
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    int ec;
                    ec = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(ec));
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Drives a request and waits (bounded) for the handshake edge; h is the
    // cycle count just after that edge. req_valid is left high.
    task automatic issue(input logic we, input logic [7:0] a, input logic [3:0] len,
                         input logic [15:0] wd, output int h);
        int t;
        t = 0;
        req_we    = we;
        req_addr  = a;
        req_len   = len;
        req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("handshake_timeout", 32'(req_ready), 32'd1);
            h = -1;
        end else begin
            @(posedge clk);
            #1;
            h = cyc;
        end
    endtask

    task automatic exp_read(input int h, input int len, input logic [15:0] d0,
                            input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i <= len; i++) begin
            rsp_t e;
            e.data = d[i];
            e.last = (i == len);
            e.cyc  = h + 1 + i;
            rsp_q.push_back(e);
        end
        done_q.push_back(h + 1 + len);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rsp_q.size() != 0 || done_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
        chk("drain_done_q", 32'(done_q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int h;
        int h2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_len   = 4'h0;
        req_wdata = 16'h0000;
        tb_clr    = 1'b1;

        // 1: reset
        repeat (2) @(negedge clk);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        tb_clr = 1'b0;
        rst_n  = 1'b1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        // 2: single read
        poke(8'h00, 16'h00ff);
        poke(8'h01, 16'h0053);
        poke(8'h02, 16'h0031);
        poke(8'h03, 16'h0016);
        issue(1'b0, 8'h03, 4'h0, 16'h0000, h);
        req_valid = 1'b0;
        exp_read(h, 0, 16'h0016, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        chk("single_mem_rd", 32'(mem_rd), 32'd1);
        chk("single_mem_addr", 32'(mem_addr), 32'h03);
        @(negedge clk);
        chk("single_mem_rd_off", 32'(mem_rd), 32'd0);
        drain();

        // 3: 4-beat read, ready low throughout
        issue(1'b0, 8'h00, 4'h3, 16'h0000, h);
        req_valid = 1'b0;
        exp_read(h, 3, 16'h00ff, 16'h0053, 16'h0031, 16'h0016);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("burst_ready_low", 32'(req_ready), 32'd0);
        end
        drain();

        // 4: wrapping write burst, then read back
        issue(1'b1, 8'hFE, 4'h3, 16'hA5A5, h);
        req_valid = 1'b0;
        done_q.push_back(h + 4);
        drain();
        chk("wrap_mem_fe", 32'(mem[8'hFE]), 32'hA5A5);
        chk("wrap_mem_ff", 32'(mem[8'hFF]), 32'hA5A5);
        chk("wrap_mem_00", 32'(mem[8'h00]), 32'hA5A5);
        chk("wrap_mem_01", 32'(mem[8'h01]), 32'hA5A5);
        chk("wrap_mem_02", 32'(mem[8'h02]), 32'h0031);
        issue(1'b0, 8'hFE, 4'h3, 16'h0000, h);
        req_valid = 1'b0;
        exp_read(h, 3, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5);
        drain();

        // 5: request held during a burst is not taken until the idle cycle
        issue(1'b0, 8'h00, 4'h3, 16'h0000, h);
        exp_read(h, 3, 16'hA5A5, 16'hA5A5, 16'h0031, 16'h0016);
        issue(1'b1, 8'h40, 4'h0, 16'hBEEF, h2);
        req_valid = 1'b0;
        done_q.push_back(h2 + 1);
        chk("accept_gap", 32'(h2 - h), 32'd5);
        drain();
        chk("held_req_mem_40", 32'(mem[8'h40]), 32'hBEEF);
        chk("held_req_mem_41", 32'(mem[8'h41]), 32'h0000);
        chk("held_req_mem_03", 32'(mem[8'h03]), 32'h0016);

        // 6: reset during third write beat
        poke(8'h12, 16'h7777);
        poke(8'h13, 16'h8888);
        issue(1'b1, 8'h10, 4'h3, 16'h1234, h);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
        chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        repeat (4) @(negedge clk);
        chk("midrst_mem_10", 32'(mem[8'h10]), 32'h1234);
        chk("midrst_mem_11", 32'(mem[8'h11]), 32'h1234);
        chk("midrst_mem_12", 32'(mem[8'h12]), 32'h7777);
        chk("midrst_mem_13", 32'(mem[8'h13]), 32'h8888);
        chk("midrst_idle_ready", 32'(req_ready), 32'd1);

        chk("rd_wr_never_both", 32'(both_hi), 32'd0);
        chk("end_rsp_q", 32'(rsp_q.size()), 32'd0);
        chk("end_done_q", 32'(done_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
